// File: rtl/dbg_controller_if.sv
// dbg_controller_if: command, CPU-control and bus signals of the debug controller.
interface dbg_controller_if;
  logic [3:0]  cmd;
  logic [31:0] addr;
  logic [31:0] d_in;
  logic        valid;
  logic        busy;
  logic [31:0] d_rd;
  logic        error;
  logic        cpu_pause;
  logic        cpu_paused;
  logic        cpu_reset;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_sel;
  logic        bus_rd;
  logic        bus_wr;
  logic        bus_ack;
  modport slave (
    input  cmd, addr, d_in, valid, cpu_paused, bus_rdata, bus_ack,
    output busy, d_rd, error, cpu_pause, cpu_reset, bus_addr, bus_wdata, bus_sel, bus_rd, bus_wr
  );
  modport master (
    output cmd, addr, d_in, valid, cpu_paused, bus_rdata, bus_ack,
    input  busy, d_rd, error, cpu_pause, cpu_reset, bus_addr, bus_wdata, bus_sel, bus_rd, bus_wr
  );
endinterface

// File: rtl/dbg_controller.sv
// dbg_controller: executes debug commands (CPU pause/resume/reset, status, memory/register access).
// Define DBG_TIMEOUT_EN to bound PAUSE_WAIT/BUS_WAIT by TIMEOUT cycles.
module dbg_controller #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic         clk,
  input logic         reset,
  dbg_controller_if.slave d
);
  typedef enum logic [2:0] {IDLE, PAUSE_WAIT, BUS_REQ, BUS_WAIT, DONE} state_t;
  state_t      state_q;
  logic        busy_q, error_q, pause_q, creset_q, rd_q, wr_q, sel_q, is_rd_q;
  logic [31:0] d_rd_q, baddr_q, bwdata_q;
  logic        is_reg, is_rd, expired;

  assign is_reg = d.cmd[3] | (d.cmd == 4'd7);
  assign is_rd  = (d.cmd == 4'd5) | (d.cmd == 4'd7);

`ifdef DBG_TIMEOUT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk)
    cnt_q <= (reset || !(state_q inside {PAUSE_WAIT, BUS_WAIT})) ? '0 : cnt_q + 16'd1;
  assign expired = cnt_q == 16'(TIMEOUT - 1);
`else
  // TIMEOUT is never 0, so without the counter the waits never expire
  assign expired = TIMEOUT == 0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      error_q  <= 1'b0;
      pause_q  <= 1'b0;
      creset_q <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      sel_q    <= 1'b0;
      is_rd_q  <= 1'b0;
      d_rd_q   <= '0;
      baddr_q  <= '0;
      bwdata_q <= '0;
    end else begin
      creset_q <= 1'b0;
      case (state_q)
        IDLE: if (d.valid) begin
          error_q <= 1'b0;
          busy_q  <= d.cmd != 4'd0;
          state_q <= DONE;
          case (d.cmd)
            4'd0: state_q <= IDLE;
            4'd1: begin
              pause_q <= 1'b1;
              if (!d.cpu_paused) state_q <= PAUSE_WAIT;
            end
            4'd2: pause_q <= 1'b0;
            4'd3: creset_q <= 1'b1;
            4'd4: d_rd_q <= {30'b0, d.cpu_paused, pause_q};
            4'd5, 4'd6, 4'd7, 4'd8: begin
              baddr_q  <= is_reg ? {27'b0, d.addr[4:0]} : d.addr;
              bwdata_q <= d.d_in;
              sel_q    <= is_reg;
              is_rd_q  <= is_rd;
              // strobe only when the CPU is halted; otherwise BUS_REQ flags the error
              rd_q     <= d.cpu_paused & is_rd;
              wr_q     <= d.cpu_paused & ~is_rd;
              state_q  <= BUS_REQ;
            end
            default: error_q <= 1'b1;
          endcase
        end
        PAUSE_WAIT: if (d.cpu_paused) state_q <= DONE;
          else if (expired) begin
            error_q <= 1'b1;
            state_q <= DONE;
          end
        BUS_REQ: begin
          rd_q <= 1'b0;
          wr_q <= 1'b0;
          if (!(rd_q | wr_q)) begin
            error_q <= 1'b1;
            state_q <= DONE;
          end else if (d.bus_ack) begin
            if (is_rd_q) d_rd_q <= d.bus_rdata;
            state_q <= DONE;
          end else state_q <= BUS_WAIT;
        end
        BUS_WAIT: if (d.bus_ack) begin
            if (is_rd_q) d_rd_q <= d.bus_rdata;
            state_q <= DONE;
          end else if (expired) begin
            error_q <= 1'b1;
            state_q <= DONE;
          end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign d.busy      = busy_q;
  assign d.error     = error_q;
  assign d.d_rd      = d_rd_q;
  assign d.cpu_pause = pause_q;
  assign d.cpu_reset = creset_q;
  assign d.bus_addr  = baddr_q;
  assign d.bus_wdata = bwdata_q;
  assign d.bus_sel   = sel_q;
  assign d.bus_rd    = rd_q;
  assign d.bus_wr    = wr_q;
endmodule
